// File: rtl/bus_cycle_ctrl.sv
// 8085-style bus cycle controller: T1/T2/TW/T3 sequencing on the multiplexed AD7-AD0 bus.
// Define BUS_WAIT_TIMEOUT_EN to bound TW states by WAIT_MAX and report timeouts.
module bus_cycle_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_wr,
    input  logic        req_io,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        timeout,
    inout  wire  [7:0]  adad,
    output logic [7:0]  a_hi,
    output logic        ale,
    output logic        rd_n,
    output logic        wr_n,
    output logic        io_m,
    input  logic        ready
);

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StTw,
        StT3
    } state_t;

    state_t     state_q;
    logic       wr_q;
    logic [7:0] wdata_q;
    logic [7:0] dout_q;
    logic       drv_q;

`ifdef BUS_WAIT_TIMEOUT_EN
    localparam logic [7:0] WaitLimit = 8'(WAIT_MAX);

    logic [7:0] wait_cnt_q;
    logic       to_flag_q;
    logic       timeout_q;

    assign timeout = timeout_q;
`else
    logic unused_wait_max;

    assign unused_wait_max = (WAIT_MAX == 0);
    assign timeout         = 1'b0;
`endif

    // The bus is released whenever drv_q is low, including asynchronously on reset.
    assign adad = drv_q ? dout_q : 8'hzz;
    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_q       <= 1'b0;
            wdata_q    <= 8'h00;
            dout_q     <= 8'h00;
            drv_q      <= 1'b0;
            a_hi       <= 8'h00;
            io_m       <= 1'b0;
            ale        <= 1'b0;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            rdata      <= 8'h00;
            done       <= 1'b0;
`ifdef BUS_WAIT_TIMEOUT_EN
            wait_cnt_q <= 8'h00;
            to_flag_q  <= 1'b0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef BUS_WAIT_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        state_q    <= StT1;
                        wr_q       <= req_wr;
                        wdata_q    <= req_wdata;
                        a_hi       <= req_addr[15:8];
                        io_m       <= req_io;
                        dout_q     <= req_addr[7:0];
                        drv_q      <= 1'b1;
                        ale        <= 1'b1;
`ifdef BUS_WAIT_TIMEOUT_EN
                        wait_cnt_q <= 8'h00;
                        to_flag_q  <= 1'b0;
`endif
                    end
                end
                StT1: begin
                    state_q <= StT2;
                    ale     <= 1'b0;
                    if (wr_q) begin
                        dout_q <= wdata_q;
                        wr_n   <= 1'b0;
                    end else begin
                        drv_q <= 1'b0;
                        rd_n  <= 1'b0;
                    end
                end
                StT2: begin
                    if (ready) begin
                        state_q <= StT3;
                    end else begin
                        state_q <= StTw;
`ifdef BUS_WAIT_TIMEOUT_EN
                        wait_cnt_q <= wait_cnt_q + 8'd1;
`endif
                    end
                end
                StTw: begin
                    if (ready) begin
                        state_q <= StT3;
`ifdef BUS_WAIT_TIMEOUT_EN
                    end else if (wait_cnt_q == WaitLimit) begin
                        // Counter equals the number of TW states already spent.
                        to_flag_q <= 1'b1;
                        state_q   <= StT3;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
`endif
                    end
                end
                StT3: begin
                    state_q <= StIdle;
                    if (!wr_q) begin
                        rdata <= adad;
                    end
                    rd_n  <= 1'b1;
                    wr_n  <= 1'b1;
                    drv_q <= 1'b0;
                    done  <= 1'b1;
`ifdef BUS_WAIT_TIMEOUT_EN
                    timeout_q <= to_flag_q;
`endif
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: vector table for zero-wait cycles plus
// hand-written wait, timeout, reset-in-TW and back-to-back sequences.
module tb_bus_cycle_ctrl;

    localparam int unsigned WaitMax = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req_wr = 1'b0;
    logic        req_io = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        ready = 1'b1;
    logic        busy, done, timeout, ale, rd_n, wr_n, io_m;
    logic [7:0]  rdata, a_hi;
    wire  [7:0]  adad;

    logic [7:0]  slave_val = 8'h00;
    logic        probe = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Slave answers reads; probe holds a known value on the otherwise floating bus.
    assign adad = !rd_n ? slave_val : (probe ? 8'h00 : 8'hzz);

    always #5 clk = ~clk;

    bus_cycle_ctrl #(.WAIT_MAX(WaitMax)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_wr    (req_wr),
        .req_io    (req_io),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .timeout   (timeout),
        .adad      (adad),
        .a_hi      (a_hi),
        .ale       (ale),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .io_m      (io_m),
        .ready     (ready)
    );

    typedef struct {
        logic        wr;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  sval;
        logic [7:0]  exp_t1;
        logic [7:0]  exp_t2;
        logic [7:0]  exp_ahi;
        logic        exp_io;
        logic [1:0]  exp_strb;   // {rd_n, wr_n} during T2/T3
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic io, input logic [15:0] addr,
                         input logic [7:0] wdata);
        req_wr    = wr;
        req_io    = io;
        req_addr  = addr;
        req_wdata = wdata;
        req       = 1'b1;
        tick();
        req       = 1'b0;
    endtask

    initial begin
        int done_at;
        int n_done;

        vecs[0] = '{1'b0, 1'b0, 16'h2050, 8'h00, 8'hA5, 8'h50, 8'hA5, 8'h20, 1'b0, 2'b01, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 16'h0081, 8'h3C, 8'h00, 8'h81, 8'h3C, 8'h00, 1'b1, 2'b10, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 16'h7F11, 8'h00, 8'h5E, 8'h11, 8'h5E, 8'h7F, 1'b1, 2'b01, 8'h5E};
        vecs[3] = '{1'b1, 1'b0, 16'hFFEE, 8'hC3, 8'h00, 8'hEE, 8'hC3, 8'hFF, 1'b0, 2'b10, 8'h5E};

        // Reset values
        probe = 1'b1;
        #12;
        check("rst_ale", ale, 1'b0);
        check("rst_strobes", {rd_n, wr_n}, 2'b11);
        check("rst_io_m", io_m, 1'b0);
        check("rst_a_hi", a_hi, 8'h00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_done_to_busy", {done, timeout, busy}, 3'b000);
        check("rst_adad_hiz", adad, 8'h00);
        rst_n = 1'b1;
        probe = 1'b0;
        tick();

        // Zero-wait cycles
        for (int i = 0; i < 4; i++) begin
            slave_val = vecs[i].sval;
            ready     = 1'b1;
            issue(vecs[i].wr, vecs[i].io, vecs[i].addr, vecs[i].wdata);
            check("t1_ale", ale, 1'b1);
            check("t1_adad", adad, vecs[i].exp_t1);
            check("t1_a_hi", a_hi, vecs[i].exp_ahi);
            check("t1_io_m", io_m, vecs[i].exp_io);
            check("t1_strobes", {rd_n, wr_n}, 2'b11);
            check("t1_busy", busy, 1'b1);
            tick();
            check("t2_ale", ale, 1'b0);
            check("t2_adad", adad, vecs[i].exp_t2);
            check("t2_strobes", {rd_n, wr_n}, vecs[i].exp_strb);
            tick();
            check("t3_strobes", {rd_n, wr_n}, vecs[i].exp_strb);
            check("t3_adad", adad, vecs[i].exp_t2);
            check("t3_done", done, 1'b0);
            tick();
            check("done", done, 1'b1);
            check("done_busy", busy, 1'b0);
            check("done_rdata", rdata, vecs[i].exp_rdata);
            check("done_strobes", {rd_n, wr_n}, 2'b11);
            check("done_timeout", timeout, 1'b0);
            tick();
            check("done_pulse", done, 1'b0);
        end
        check("idle_a_hi_hold", a_hi, 8'hFF);
        check("idle_io_m_hold", io_m, 1'b0);

        // Two wait states: done expected 6 cycles after the request edge
        slave_val = 8'h99;
        ready     = 1'b0;
        issue(1'b0, 1'b0, 16'h3344, 8'h00);
        done_at = 0;
        for (int c = 2; c <= 12; c++) begin
            tick();
            ready = (c >= 4);
            if (c == 3 || c == 4) begin
                check("tw_rd_n", rd_n, 1'b0);
                check("tw_busy", busy, 1'b1);
            end
            if (done) begin
                done_at = c;
                break;
            end
        end
        check("wait2_done_cycle", 16'(done_at), 16'd6);
        check("wait2_rdata", rdata, 8'h99);
        ready = 1'b1;
        tick();

`ifdef BUS_WAIT_TIMEOUT_EN
        // ready held low: 3 TW states, T3 in cycle 6, done+timeout in cycle 7
        slave_val = 8'h0F;
        ready     = 1'b0;
        issue(1'b0, 1'b0, 16'h0102, 8'h00);
        done_at = 0;
        for (int c = 2; c <= 15; c++) begin
            tick();
            if (done) begin
                done_at = c;
                check("timeout_flag", timeout, 1'b1);
                break;
            end
        end
        check("timeout_done_cycle", 16'(done_at), 16'd7);
        check("timeout_rdata", rdata, 8'h0F);
        ready = 1'b1;
        tick();
        check("timeout_clear", {done, timeout}, 2'b00);
`else
        // Without the limit TW must persist until ready rises
        slave_val = 8'h0F;
        ready     = 1'b0;
        issue(1'b0, 1'b0, 16'h0102, 8'h00);
        n_done = 0;
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (done) n_done++;
        end
        check("tw_hold_no_done", 16'(n_done), 16'd0);
        check("tw_hold_busy", busy, 1'b1);
        check("tw_hold_rd_n", rd_n, 1'b0);
        ready = 1'b1;
        tick();
        tick();
        check("tw_release_done", done, 1'b1);
        check("tw_release_timeout", timeout, 1'b0);
        check("tw_release_rdata", rdata, 8'h0F);
        tick();
`endif

        // Reset while in TW of a write
        ready = 1'b0;
        issue(1'b1, 1'b1, 16'h4455, 8'h77);
        tick();
        tick();
        check("pre_rst_wr_n", wr_n, 1'b0);
        check("pre_rst_adad", adad, 8'h77);
        #2;
        rst_n = 1'b0;
        probe = 1'b1;
        #1;
        check("rst_tw_strobes", {rd_n, wr_n}, 2'b11);
        check("rst_tw_adad_hiz", adad, 8'h00);
        check("rst_tw_ale", ale, 1'b0);
        check("rst_tw_flags", {done, timeout, busy}, 3'b000);
        check("rst_tw_a_hi", a_hi, 8'h00);
        check("rst_tw_io_m", io_m, 1'b0);
        check("rst_tw_rdata", rdata, 8'h00);
        #10;
        rst_n = 1'b1;
        probe = 1'b0;
        ready = 1'b1;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done || busy) n_done++;
        end
        check("rst_tw_dropped", 16'(n_done), 16'd0);

        // Back-to-back: second req held from T1 through the done cycle
        slave_val = 8'h42;
        ready     = 1'b1;
        issue(1'b0, 1'b0, 16'h1000, 8'h00);
        req_wr    = 1'b1;
        req_addr  = 16'h1001;
        req_wdata = 8'h24;
        req       = 1'b1;
        tick();
        check("b2b_t2_ale", ale, 1'b0);
        check("b2b_t2_strobes", {rd_n, wr_n}, 2'b01);
        tick();
        check("b2b_t3_strobes", {rd_n, wr_n}, 2'b01);
        tick();
        check("b2b_done1", done, 1'b1);
        check("b2b_rdata", rdata, 8'h42);
        check("b2b_done_busy", busy, 1'b0);
        tick();
        req = 1'b0;
        check("b2b_t1_ale", ale, 1'b1);
        check("b2b_t1_adad", adad, 8'h01);
        check("b2b_t1_a_hi", a_hi, 8'h10);
        check("b2b_t1_busy", busy, 1'b1);
        tick();
        check("b2b_w_strobes", {rd_n, wr_n}, 2'b10);
        check("b2b_w_adad", adad, 8'h24);
        tick();
        tick();
        check("b2b_done2", done, 1'b1);
        check("b2b_rdata_hold", rdata, 8'h42);
        tick();
        check("b2b_idle", {done, busy}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
